data_package_mc: RTL and testbench
==================================

DATA_PACKAGE_MC -- requirements
Module: data_package_mc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one data word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7: per-channel depth is 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter CH_NUM, default 4: number of type channels, legal range 2..16; localparam TYPE_WIDTH = clog2(CH_NUM); localparam NUM_WIDTH = ADDR_WIDTH+TYPE_WIDTH+1.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port wen, input, 1: write enable; one word is accepted per cycle while high.
REQ-007 SHALL have port pkg_in, input, DATA_WIDTH: write data.
REQ-008 SHALL have port type, input, TYPE_WIDTH: destination channel of pkg_in.
REQ-009 SHALL have port pkg_rdy, input, 1: downstream accepts pkg_out this cycle.
REQ-010 SHALL have port pkg_out, output, DATA_WIDTH: read data.
REQ-011 SHALL have port pkg_out_vld, output, 1: pkg_out is valid.
REQ-012 SHALL have port pkg_out_type, output, TYPE_WIDTH: channel of the current pkg_out.
REQ-013 SHALL have port pkg_num, output, NUM_WIDTH: total words stored in the burst.
REQ-014 SHALL have port pkg_num_vld, output, 1: pkg_num is valid.
REQ-015 SHALL have port busy, output, 1: block is draining and ignores wen.
REQ-016 SHALL have port ovf, output, 1: sticky drop flag.

Function
REQ-017 SHALL implement three states:
- IDLE: empty; wen=1 writes the word and moves to FILL.
- FILL: wen=1 writes; wen=0 moves to DRAIN on the same edge.
- DRAIN: reads out the stored data; returns to IDLE on the edge that consumes the last word.
REQ-018 A write SHALL store pkg_in at the tail of channel type, and SHALL increment that channel's count (ADDR_WIDTH+1 bits).
REQ-019 A write to a full channel (count = 2**ADDR_WIDTH) or with type >= CH_NUM SHALL be dropped and SHALL set ovf; the other channels are unaffected.
REQ-020 ovf SHALL clear on the IDLE->FILL edge and on rst only.
REQ-021 On the FILL->DRAIN edge, pkg_num SHALL be loaded with the sum of all channel counts; pkg_num SHALL stay constant and pkg_num_vld=1 throughout DRAIN.
REQ-022 pkg_num_vld SHALL be asserted the first cycle after the edge sampling wen=0 in FILL (latency 1).
REQ-023 In DRAIN:
- pkg_out_vld SHALL be 1.
- The selected channel SHALL be the highest-indexed non-empty channel.
- pkg_out and pkg_out_type SHALL show that channel's head word combinationally from the registered read pointer (asynchronous read).
REQ-024 A word SHALL be consumed on a posedge with pkg_out_vld & pkg_rdy; the next word SHALL appear the following cycle with no bubble, including across a channel switch.
REQ-025 Within a channel, read order SHALL be write order (FIFO); across channels, order SHALL be CH_NUM-1 down to 0, and empty channels SHALL be skipped.
REQ-026 pkg_rdy=0 SHALL hold pkg_out, pkg_out_type and the read pointers unchanged.
REQ-027 busy SHALL equal (state==DRAIN); wen SHALL be ignored in DRAIN, with no store and no ovf.
REQ-028 A burst in which every write was dropped SHALL go FILL->IDLE directly when wen=0: no DRAIN, pkg_num_vld stays 0, ovf stays 1.
REQ-029 On DRAIN->IDLE, all counts and pointers SHALL clear; wen=1 in the first IDLE cycle SHALL start a new burst.
REQ-030 Outside DRAIN, pkg_out and pkg_out_type SHALL be 0 and pkg_out_vld SHALL be 0.

Reset
REQ-031 rst=1 at a posedge SHALL force IDLE and clear counts, pointers, pkg_num, pkg_num_vld, pkg_out_vld, busy and ovf to 0 on that edge, in any state including mid-FILL and mid-DRAIN; rst SHALL override wen.
REQ-032 Memory contents SHALL NOT be reset.

Structure
REQ-033 Package data_package_pkg SHALL hold the state encoding (IDLE, FILL, DRAIN) and the clog2 function.
REQ-034 Sub-module pkg_chan_buf SHALL be instantiated CH_NUM times; each instance holds one channel's RAM, write/read pointers and count, with an empty/full indication.
REQ-035 The top level SHALL hold the FSM, the channel priority select and pkg_num summation.

Verification
REQ-036 Default parameters; write 5 words to type 3, then 4 words to type 0, drop wen -> one cycle later pkg_num=9 with vld; 5 type-3 words then 4 type-0 words in order, pkg_out_type 3 then 0, 9 cycles with pkg_rdy=1.
REQ-037 Types 2, 0, 2, 1 interleaved (one word each); toggle pkg_rdy 1,0,1,0 during drain -> words held while rdy=0; order is type 2 (FIFO), 1, 0; no bubble at channel switches.
REQ-038 Write 130 words to type 1 (ADDR_WIDTH=7) -> ovf=1; pkg_num=128; words 0..127 read back; drain completes in 128 accepted cycles.
REQ-039 wen=1 held during DRAIN with type 2 data -> no change to pkg_num or output data, and ovf stays 0.
REQ-040 Assert rst for one cycle at word 3 of drain -> next cycle state IDLE, all outputs 0; a fresh 4-word burst reads back correctly.
REQ-041 CH_NUM=3: write with type=3 only, then wen=0 -> ovf=1, pkg_num_vld never asserted, busy=0.

Source files
------------

// File: rtl/data_package_pkg.sv
// Shared definitions for the multi-channel data packager: FSM encoding and a
// constant-evaluable ceiling log2 used to size the channel-type field.
package data_package_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Ceiling log2 for elaboration-time width computation (clog2(1) = 0).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((32'd1 << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/pkg_chan_buf.sv
// One channel store: a small FIFO with asynchronous read of the head word.
module pkg_chan_buf #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign wr_ok     = wr_en_i & ~full_o;
    assign rd_ok     = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy bookkeeping; cleared at burst end or reset.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
            if (rd_ok) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/data_package_mc.sv
// Burst packager: collects words into per-type channels, then drains them
// highest channel first, FIFO within a channel, reporting the burst size.
module data_package_mc
    import data_package_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 8,
    parameter  int unsigned ADDR_WIDTH = 7,
    parameter  int unsigned CH_NUM     = 4,
    localparam int unsigned TYPE_WIDTH = clog2(CH_NUM),
    localparam int unsigned NUM_WIDTH  = ADDR_WIDTH + TYPE_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] pkg_in,
    input  logic [TYPE_WIDTH-1:0] pkg_type,
    input  logic                  pkg_rdy,
    output logic [DATA_WIDTH-1:0] pkg_out,
    output logic                  pkg_out_vld,
    output logic [TYPE_WIDTH-1:0] pkg_out_type,
    output logic [NUM_WIDTH-1:0]  pkg_num,
    output logic                  pkg_num_vld,
    output logic                  busy,
    output logic                  ovf
);

    state_e                state_q, state_d;
    logic [NUM_WIDTH-1:0]  pkg_num_q, pkg_num_d;
    logic                  pkg_num_vld_q, pkg_num_vld_d;
    logic                  ovf_q, ovf_d;

    logic [CH_NUM-1:0]     wr_en, rd_en, empty, full;
    logic [DATA_WIDTH-1:0] rd_data [CH_NUM];
    logic [ADDR_WIDTH:0]   count   [CH_NUM];

    logic                  drain_c, accept_c, type_ok_c, tgt_full_c, drop_c;
    logic                  any_c, clr_c;
    logic [TYPE_WIDTH-1:0] sel_c;
    logic [NUM_WIDTH-1:0]  total_c;

    assign drain_c   = (state_q == DRAIN);
    assign accept_c  = wen & ((state_q == IDLE) | (state_q == FILL));
    assign type_ok_c = (32'(pkg_type) < CH_NUM);
    assign drop_c    = accept_c & (~type_ok_c | tgt_full_c);

    // Channel stores with write steering and read-side priority grant.
    for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
        assign wr_en[g] = accept_c & type_ok_c & (pkg_type == TYPE_WIDTH'(g));
        assign rd_en[g] = drain_c & pkg_rdy & any_c & (sel_c == TYPE_WIDTH'(g));

        pkg_chan_buf #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_buf (
            .clk       (clk),
            .rst       (rst),
            .clr_i     (clr_c),
            .wr_en_i   (wr_en[g]),
            .wr_data_i (pkg_in),
            .rd_en_i   (rd_en[g]),
            .rd_data_o (rd_data[g]),
            .count_o   (count[g]),
            .empty_o   (empty[g]),
            .full_o    (full[g])
        );
    end

    // Highest non-empty channel wins; also totals occupancy and looks up target fullness.
    always_comb begin
        sel_c      = '0;
        any_c      = 1'b0;
        total_c    = '0;
        tgt_full_c = 1'b0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (!empty[i]) begin
                sel_c = TYPE_WIDTH'(i);
                any_c = 1'b1;
            end
            total_c = total_c + NUM_WIDTH'(count[i]);
            if (pkg_type == TYPE_WIDTH'(i)) tgt_full_c = full[i];
        end
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pkg_num_q     <= '0;
            pkg_num_vld_q <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            pkg_num_q     <= pkg_num_d;
            pkg_num_vld_q <= pkg_num_vld_d;
            ovf_q         <= ovf_d;
        end
    end

    // Next-state: a dropped first write still opens the burst and flags ovf.
    always_comb begin
        state_d       = state_q;
        pkg_num_d     = pkg_num_q;
        pkg_num_vld_d = pkg_num_vld_q;
        ovf_d         = ovf_q;
        clr_c         = 1'b0;
        case (state_q)
            IDLE: begin
                if (wen) begin
                    state_d = FILL;
                    ovf_d   = drop_c;
                end
            end
            FILL: begin
                if (drop_c) ovf_d = 1'b1;
                if (!wen) begin
                    if (total_c == '0) begin
                        state_d = IDLE;
                    end else begin
                        state_d       = DRAIN;
                        pkg_num_d     = total_c;
                        pkg_num_vld_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (pkg_rdy && (total_c == NUM_WIDTH'(1))) begin
                    state_d       = IDLE;
                    pkg_num_d     = '0;
                    pkg_num_vld_d = 1'b0;
                    clr_c         = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Head word of the granted channel is shown only while draining.
    always_comb begin
        pkg_out      = '0;
        pkg_out_type = '0;
        if (drain_c) begin
            pkg_out      = rd_data[sel_c];
            pkg_out_type = sel_c;
        end
    end

    assign pkg_out_vld = drain_c;
    assign busy        = drain_c;
    assign pkg_num     = pkg_num_q;
    assign pkg_num_vld = pkg_num_vld_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_data_package_mc.sv
// Scoreboard bench for data_package_mc: stimulus queues expected words,
// a negedge monitor compares whatever the DUT presents.
module tb_data_package_mc;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, wen, pkg_rdy;
    logic [7:0] pkg_in;
    logic [1:0] pkg_type;
    logic [7:0] pkg_out;
    logic       pkg_out_vld;
    logic [1:0] pkg_out_type;
    logic [9:0] pkg_num;
    logic       pkg_num_vld, busy, ovf;

    logic       wen3, rdy3;
    logic [7:0] in3;
    logic [1:0] type3;
    logic [7:0] out3;
    logic       out_vld3;
    logic [1:0] out_type3;
    logic [9:0] num3;
    logic       num_vld3, busy3, ovf3;

    data_package_mc dut (
        .clk          (clk),
        .rst          (rst),
        .wen          (wen),
        .pkg_in       (pkg_in),
        .pkg_type     (pkg_type),
        .pkg_rdy      (pkg_rdy),
        .pkg_out      (pkg_out),
        .pkg_out_vld  (pkg_out_vld),
        .pkg_out_type (pkg_out_type),
        .pkg_num      (pkg_num),
        .pkg_num_vld  (pkg_num_vld),
        .busy         (busy),
        .ovf          (ovf)
    );

    data_package_mc #(.CH_NUM(3)) dut3 (
        .clk          (clk),
        .rst          (rst),
        .wen          (wen3),
        .pkg_in       (in3),
        .pkg_type     (type3),
        .pkg_rdy      (rdy3),
        .pkg_out      (out3),
        .pkg_out_vld  (out_vld3),
        .pkg_out_type (out_type3),
        .pkg_num      (num3),
        .pkg_num_vld  (num_vld3),
        .busy         (busy3),
        .ovf          (ovf3)
    );

    typedef struct packed {
        logic [1:0] t;
        logic [7:0] d;
    } exp_t;

    exp_t sb_q[$];
    exp_t wr_log[$];
    int   cnt[4];
    int   checks = 0;
    int   fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: head word must match the scoreboard front; popped when accepted.
    always @(negedge clk) begin
        if (pkg_out_vld === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL sb_empty: got word %0h type %0h expected none", pkg_out, pkg_out_type);
            end else begin
                check("out_data", 32'(pkg_out), 32'(sb_q[0].d));
                check("out_type", 32'(pkg_out_type), 32'(sb_q[0].t));
                if (pkg_rdy) void'(sb_q.pop_front());
            end
        end else begin
            check("idle_out", 32'({pkg_out_type, pkg_out}), 32'd0);
        end
    end

    // One write; the model keeps at most 128 words per channel.
    task automatic wr(input logic [1:0] t, input logic [7:0] d);
        exp_t e;
        wen      = 1'b1;
        pkg_type = t;
        pkg_in   = d;
        if (cnt[t] < 128) begin
            e.t = t;
            e.d = d;
            wr_log.push_back(e);
            cnt[t]++;
        end
        @(posedge clk); #1;
    endtask

    // Close the burst and queue the expected readout order.
    task automatic end_burst();
        wen = 1'b0;
        for (int c = 3; c >= 0; c--) begin
            foreach (wr_log[k]) if (wr_log[k].t == 2'(c)) sb_q.push_back(wr_log[k]);
        end
        wr_log.delete();
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        @(posedge clk); #1;
    endtask

    // Drain with rdy always high (mode 0) or toggling 1,0,... (mode 1).
    task automatic drain(input int exp_num, input int mode, input bit hold_wen,
                         input int rst_at, input int exp_cycles);
        int cyc;
        cyc = 0;
        while (busy && cyc < 400) begin
            pkg_rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (hold_wen) begin
                wen      = 1'b1;
                pkg_type = 2'd2;
                pkg_in   = 8'hEE;
            end
            if (cyc == rst_at) rst = 1'b1;
            check("num_hold", 32'(pkg_num), 32'(exp_num));
            check("num_vld_hold", 32'(pkg_num_vld), 32'd1);
            @(posedge clk); #1;
            cyc++;
            if (rst) begin
                rst = 1'b0;
                sb_q.delete();
                break;
            end
        end
        wen     = 1'b0;
        pkg_rdy = 1'b0;
        if (rst_at < 0) begin
            check("drain_cycles", 32'(cyc), 32'(exp_cycles));
            check("sb_drained", 32'(sb_q.size()), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        rst = 1'b1; wen = 1'b0; pkg_in = '0; pkg_type = '0; pkg_rdy = 1'b0;
        wen3 = 1'b0; rdy3 = 1'b0; in3 = '0; type3 = '0;
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_num", 32'(pkg_num), 32'd0);
        check("rst_num_vld", 32'(pkg_num_vld), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_out_vld", 32'(pkg_out_vld), 32'd0);
        rst = 1'b0;

        // Two channels, straight drain.
        for (int i = 0; i < 5; i++) wr(2'd3, 8'h30 + 8'(i));
        for (int i = 0; i < 4; i++) wr(2'd0, 8'hA0 + 8'(i));
        end_burst();
        check("b1_num", 32'(pkg_num), 32'd9);
        check("b1_num_vld", 32'(pkg_num_vld), 32'd1);
        check("b1_busy", 32'(busy), 32'd1);
        drain(9, 0, 1'b0, -1, 9);

        // Interleaved types with backpressure.
        wr(2'd2, 8'h21); wr(2'd0, 8'h01); wr(2'd2, 8'h22); wr(2'd1, 8'h11);
        end_burst();
        check("b2_num", 32'(pkg_num), 32'd4);
        drain(4, 1, 1'b0, -1, 7);

        // Overflow of one channel.
        for (int i = 0; i < 130; i++) wr(2'd1, 8'(i));
        end_burst();
        check("b3_ovf", 32'(ovf), 32'd1);
        check("b3_num", 32'(pkg_num), 32'd128);
        drain(128, 0, 1'b0, -1, 128);
        check("b3_ovf_sticky", 32'(ovf), 32'd1);

        // wen held during drain is ignored; ovf cleared on burst start.
        wr(2'd1, 8'h51);
        check("b4_ovf_clr", 32'(ovf), 32'd0);
        wr(2'd1, 8'h52); wr(2'd1, 8'h53);
        end_burst();
        check("b4_num", 32'(pkg_num), 32'd3);
        drain(3, 0, 1'b1, -1, 3);
        check("b4_ovf", 32'(ovf), 32'd0);
        check("b4_idle", 32'(busy), 32'd0);

        // Reset in the middle of a drain, then a fresh burst.
        for (int i = 0; i < 6; i++) wr(2'd0, 8'h60 + 8'(i));
        end_burst();
        drain(6, 0, 1'b0, 3, 0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_out_vld", 32'(pkg_out_vld), 32'd0);
        check("r_num_vld", 32'(pkg_num_vld), 32'd0);
        check("r_num", 32'(pkg_num), 32'd0);
        check("r_ovf", 32'(ovf), 32'd0);
        check("r_out", 32'({pkg_out_type, pkg_out}), 32'd0);
        for (int i = 0; i < 4; i++) wr(2'd2, 8'h71 + 8'(i));
        end_burst();
        check("b5_num", 32'(pkg_num), 32'd4);
        drain(4, 0, 1'b0, -1, 4);

        // Three-channel instance: an out-of-range type only.
        wen3 = 1'b1; type3 = 2'd3; in3 = 8'h99;
        @(posedge clk); #1;
        check("c3_ovf_set", 32'(ovf3), 32'd1);
        wen3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("c3_num_vld", 32'(num_vld3), 32'd0);
            check("c3_busy", 32'(busy3), 32'd0);
            check("c3_ovf", 32'(ovf3), 32'd1);
        end
        wen3 = 1'b1; type3 = 2'd2; in3 = 8'h5A;
        @(posedge clk); #1;
        check("c3_ovf_clr", 32'(ovf3), 32'd0);
        wen3 = 1'b0;
        @(posedge clk); #1;
        check("c3_num", 32'(num3), 32'd1);
        check("c3_out", 32'({out_type3, out3}), 32'h25A);
        check("c3_drain_busy", 32'(busy3), 32'd1);
        rdy3 = 1'b1;
        @(posedge clk); #1;
        check("c3_done", 32'(busy3), 32'd0);
        rdy3 = 1'b0;

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
